spad_read_arbiter: RTL and testbench
====================================

# spad_read_arbiter

Shares the single read port of a PE scratchpad (SPad) between NUM_REQ requesters, such as the MAC datapath, the psum drain and the debug readout, using round-robin burst arbitration. It accepts one burst request at a time and issues consecutive-address reads to the SPad. It returns the data tagged with the requester ID. The SPad write port passes through the block so that same-cycle write/read collisions are resolved in one place. It sits between the requesters and the SPad instance inside a PE.

## Interface
Parameters:
- NUM_REQ, 4: number of read requesters (≥2)
- DATA_BITWIDTH, 16: SPad word width
- ADDR_BITWIDTH, 9: SPad address width
- LEN_BITWIDTH, 4: burst-length field width; beats = req_len+1

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-low: asserted when 0 and sampled on posedge clk
- req_valid  in  NUM_REQ  per-requester burst request
- req_addr  in  NUM_REQ*ADDR_BITWIDTH  start address; requester i occupies slice i
- req_len  in  NUM_REQ*LEN_BITWIDTH  beats-1 per requester
- req_ready  out  NUM_REQ  one-hot acceptance pulse
- rsp_valid  out  1  response beat valid
- rsp_id  out  $clog2(NUM_REQ)  requester that owns the beat
- rsp_data  out  DATA_BITWIDTH  read data
- rsp_last  out  1  final beat of the burst
- wr_en  in  1  write request (single writer, never stalled)
- wr_addr  in  ADDR_BITWIDTH  write address
- wr_data  in  DATA_BITWIDTH  write data
- spad_read_req  out  1  to SPad read_req
- spad_r_addr  out  ADDR_BITWIDTH  to SPad r_addr
- spad_write_en  out  1  to SPad write_en
- spad_w_addr  out  ADDR_BITWIDTH  to SPad w_addr
- spad_w_data  out  DATA_BITWIDTH  to SPad w_data
- spad_r_data  in  DATA_BITWIDTH  from SPad r_data, valid one cycle after spad_read_req

## Operation
- FSM states: IDLE and BURST.
- IDLE: if any req_valid is set, grant the first requester at or after rr_ptr in circular order.
  - Assert req_ready[g] combinationally in that cycle.
  - Latch cur_addr=req_addr[g], beats_left=req_len[g] and cur_id=g.
  - Set rr_ptr=(g+1) mod NUM_REQ and go to BURST.
- BURST: spad_read_req=1 and spad_r_addr=cur_addr, both registered outputs.
  - Each cycle: cur_addr+1, wrapping modulo 2^ADDR_BITWIDTH (511→0); beats_left-1.
  - Last issue cycle (beats_left==0): arbitration runs again. If a request is pending, accept it and stay in BURST with no bubble. Otherwise go to IDLE.
- Requesters hold req_valid, req_addr and req_len stable until req_ready. A requester may withdraw req_valid before acceptance.
- Response pipeline: one register stage carries id, last and a valid flag aligned to SPad read latency. rsp_valid is the delayed spad_read_req.
- rsp_data=spad_r_data when rsp_valid=1, else 0. The SPad filler value is never forwarded.
- There is no response backpressure; requesters must accept every beat.
- Write port is a combinational pass-through: spad_write_en = wr_en & reset, with wr_addr and wr_data forwarded unchanged.
- Reset (reset=0 at posedge):
  - FSM goes to IDLE, rr_ptr=0, spad_read_req=0, spad_r_addr=0.
  - rsp_valid=0, rsp_id=0, rsp_last=0, rsp_data=0, req_ready=0.
  - An in-flight burst is abandoned; no beats are emitted after reset.

## Timing
- Request accepted (req_ready) in cycle t.
- First SPad read is issued at t+1; first rsp_valid is at t+2.
- A burst of L=req_len+1 beats occupies issue cycles t+1..t+L and response cycles t+2..t+L+1.
- rsp_last coincides with the beat in cycle t+L+1.
- Back-to-back bursts have zero idle issue cycles between them.
- Worst-case wait for a continuously requesting requester: (NUM_REQ-1) bursts.

## Configuration
- SPAD_ARB_WR_BYPASS_EN defined:
  - When a read is issued in the same cycle as wr_en with wr_addr==spad_r_addr, latch wr_data.
  - The corresponding response beat returns the new data.
- SPAD_ARB_WR_BYPASS_EN undefined: that beat returns the SPad's pre-write contents (old data).

## Structure
- Package spad_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - the ID width localparam function;
  - the response-stage struct (valid, id, last, bypass_hit, bypass_data).
- Sub-module rr_arbiter(NUM_REQ) provides combinational round-robin grant from a request vector and rr_ptr, producing a one-hot grant plus an encoded index.

## Test plan
- Single burst: req 0, addr 0x010, len 3 → req_ready[0] at t; spad_r_addr 0x010..0x013 at t+1..t+4; 4 beats with rsp_id=0 and mem data; rsp_last on the 4th beat.
- Fairness: all 4 requesters valid continuously with len 0 → grant order 0,1,2,3,0,…; one beat per cycle with no bubbles.
- Wrap-around: addr 0x1FE, len 3 → addresses 0x1FE, 0x1FF, 0x000, 0x001.
- Collision: read of 0x020 issued while wr_en writes 0x020 := 0xBEEF over old 0x1234 → response 0xBEEF with the macro, 0x1234 without.
- Reset mid-burst: reset=0 during beat 2 of a len-7 burst → next cycle all outputs 0, no further rsp_valid, first grant after release goes to requester 0.
- Withdrawn request: req 2 drops req_valid before grant while req 3 is pending → req 3 is granted and req_ready[2] is never asserted.

Source files
------------

// File: rtl/spad_arb_pkg.sv
// Shared types for the SPad read arbiter: FSM states, ID width helper and
// the response-stage record.
package spad_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    function automatic int id_bits(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Stage fields are sized for the default PE configuration (4 requesters, 16-bit words).
    localparam int RSP_ID_BITWIDTH   = id_bits(4);
    localparam int RSP_DATA_BITWIDTH = 16;

    typedef struct packed {
        logic                         valid;
        logic [RSP_ID_BITWIDTH-1:0]   id;
        logic                         last;
        logic                         bypass_hit;
        logic [RSP_DATA_BITWIDTH-1:0] bypass_data;
    } rsp_stage_t;

endpackage

// File: rtl/spad_read_arbiter_if.sv
// Requester-side bundle of the SPad read arbiter: burst requests in, tagged
// read beats out. The master modport is the requester side.
interface spad_read_arbiter_if
    import spad_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 9,
    parameter int LEN_BITWIDTH  = 4
);
    localparam int ID_W = id_bits(NUM_REQ);

    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ*ADDR_BITWIDTH-1:0] req_addr;
    logic [NUM_REQ*LEN_BITWIDTH-1:0]  req_len;
    logic [NUM_REQ-1:0]               req_ready;
    logic                             rsp_valid;
    logic [ID_W-1:0]                  rsp_id;
    logic [DATA_BITWIDTH-1:0]         rsp_data;
    logic                             rsp_last;

    modport master (
        output req_valid, req_addr, req_len,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_last
    );

    modport slave (
        input  req_valid, req_addr, req_len,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_last
    );

endinterface

// File: rtl/spad_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr in
// circular order, as one-hot grant plus encoded index.
module rr_arbiter
    import spad_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    logic [ID_W-1:0] cand_s;

    // Scan from ptr around the ring and stop at the first live request
    always_comb begin
        grant     = {NUM_REQ{1'b0}};
        grant_idx = {ID_W{1'b0}};
        grant_any = 1'b0;
        cand_s    = {ID_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!grant_any && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                grant_idx     = cand_s;
                grant_any     = 1'b1;
            end else begin
                grant_any = grant_any;
            end
        end
    end

endmodule

// File: rtl/spad_read_arbiter.sv
// Round-robin burst arbiter for the PE scratchpad read port, with write-port
// pass-through. Optional write->read bypass: SPAD_ARB_WR_BYPASS_EN.
module spad_read_arbiter
    import spad_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 9,
    parameter int LEN_BITWIDTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    spad_read_arbiter_if.slave       bus,
    input  logic                     wr_en,
    input  logic [ADDR_BITWIDTH-1:0] wr_addr,
    input  logic [DATA_BITWIDTH-1:0] wr_data,
    output logic                     spad_read_req,
    output logic [ADDR_BITWIDTH-1:0] spad_r_addr,
    output logic                     spad_write_en,
    output logic [ADDR_BITWIDTH-1:0] spad_w_addr,
    output logic [DATA_BITWIDTH-1:0] spad_w_data,
    input  logic [DATA_BITWIDTH-1:0] spad_r_data
);

    localparam int ID_W = id_bits(NUM_REQ);

    arb_state_e               state_r;
    logic [ID_W-1:0]          rr_ptr_r;
    logic [ID_W-1:0]          cur_id_r;
    logic [ADDR_BITWIDTH-1:0] cur_addr_r;
    logic [LEN_BITWIDTH-1:0]  beats_left_r;
    logic                     spad_read_req_r;
    rsp_stage_t               rsp_stage_r;

    logic [NUM_REQ-1:0]       grant_s;
    logic [ID_W-1:0]          grant_idx_s;
    logic                     grant_any_s;
    logic                     arb_open_s;
    logic                     accept_s;
    logic [ADDR_BITWIDTH-1:0] grant_addr_s;
    logic [LEN_BITWIDTH-1:0]  grant_len_s;
    logic                     bypass_hit_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    // Arbitration is open when idle or on the last issue beat, so bursts chain without a bubble
    always_comb begin
        arb_open_s = 1'b0;
        case (state_r)
            IDLE:    arb_open_s = 1'b1;
            BURST:   arb_open_s = (beats_left_r == {LEN_BITWIDTH{1'b0}});
            default: arb_open_s = 1'b0;
        endcase
        accept_s     = reset & arb_open_s & grant_any_s;
        grant_addr_s = {ADDR_BITWIDTH{1'b0}};
        grant_len_s  = {LEN_BITWIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                grant_addr_s = bus.req_addr[i*ADDR_BITWIDTH +: ADDR_BITWIDTH];
                grant_len_s  = bus.req_len[i*LEN_BITWIDTH +: LEN_BITWIDTH];
            end else begin
                grant_addr_s = grant_addr_s;
            end
        end
        if (accept_s) begin
            bus.req_ready = grant_s;
        end else begin
            bus.req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Burst FSM: cur_addr_r is the address issued this cycle, beats_left_r the beats after it
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= IDLE;
            rr_ptr_r        <= {ID_W{1'b0}};
            cur_id_r        <= {ID_W{1'b0}};
            cur_addr_r      <= {ADDR_BITWIDTH{1'b0}};
            beats_left_r    <= {LEN_BITWIDTH{1'b0}};
            spad_read_req_r <= 1'b0;
        end else if (accept_s) begin
            state_r         <= BURST;
            spad_read_req_r <= 1'b1;
            cur_addr_r      <= grant_addr_s;
            beats_left_r    <= grant_len_s;
            cur_id_r        <= grant_idx_s;
            rr_ptr_r        <= (grant_idx_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}}
                                                                   : grant_idx_s + ID_W'(1);
        end else begin
            case (state_r)
                BURST: begin
                    if (beats_left_r != {LEN_BITWIDTH{1'b0}}) begin
                        cur_addr_r   <= cur_addr_r + ADDR_BITWIDTH'(1);
                        beats_left_r <= beats_left_r - LEN_BITWIDTH'(1);
                    end else begin
                        state_r         <= IDLE;
                        spad_read_req_r <= 1'b0;
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    spad_read_req_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPAD_ARB_WR_BYPASS_EN
    assign bypass_hit_s = spad_read_req_r & wr_en & (wr_addr == cur_addr_r);
`else
    assign bypass_hit_s = 1'b0;
`endif

    // Response stage aligned to the one-cycle SPad read latency
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_stage_r <= '0;
        end else begin
            rsp_stage_r.valid       <= spad_read_req_r;
            rsp_stage_r.id          <= spad_read_req_r ? RSP_ID_BITWIDTH'(cur_id_r)
                                                       : {RSP_ID_BITWIDTH{1'b0}};
            rsp_stage_r.last        <= spad_read_req_r & (beats_left_r == {LEN_BITWIDTH{1'b0}});
            rsp_stage_r.bypass_hit  <= bypass_hit_s;
            rsp_stage_r.bypass_data <= RSP_DATA_BITWIDTH'(wr_data);
        end
    end

    // The SPad filler value is masked whenever no beat is in flight
    always_comb begin
        if (rsp_stage_r.valid) begin
            if (rsp_stage_r.bypass_hit) begin
                bus.rsp_data = DATA_BITWIDTH'(rsp_stage_r.bypass_data);
            end else begin
                bus.rsp_data = spad_r_data;
            end
        end else begin
            bus.rsp_data = {DATA_BITWIDTH{1'b0}};
        end
    end

    assign bus.rsp_valid = rsp_stage_r.valid;
    assign bus.rsp_id    = ID_W'(rsp_stage_r.id);
    assign bus.rsp_last  = rsp_stage_r.last;

    assign spad_read_req = spad_read_req_r;
    assign spad_r_addr   = cur_addr_r;
    assign spad_write_en = wr_en & reset;
    assign spad_w_addr   = wr_addr;
    assign spad_w_data   = wr_data;

endmodule

// File: tb/tb_spad_read_arbiter.sv
// Directed bench for spad_read_arbiter: burst table plus hand-written
// collision, reset, fairness and withdrawal sequences against a SPad model.
module tb_spad_read_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int AW = 9;
    localparam int LW = 4;

    typedef struct {
        int             rid;
        logic [AW-1:0]  addr;
        logic [LW-1:0]  len;
        logic [AW-1:0]  exp_last;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          spad_read_req;
    logic [AW-1:0] spad_r_addr;
    logic          spad_write_en;
    logic [AW-1:0] spad_w_addr;
    logic [DW-1:0] spad_w_data;
    logic [DW-1:0] spad_r_data;

    logic [DW-1:0] mem [512];
    logic          mem_init_done = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;

    spad_read_arbiter_if #(.NUM_REQ(NR), .DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .LEN_BITWIDTH(LW)) bif ();

    spad_read_arbiter #(.NUM_REQ(NR), .DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .LEN_BITWIDTH(LW)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bif),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .spad_read_req (spad_read_req),
        .spad_r_addr   (spad_r_addr),
        .spad_write_en (spad_write_en),
        .spad_w_addr   (spad_w_addr),
        .spad_w_data   (spad_w_data),
        .spad_r_data   (spad_r_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        logic [DW-1:0] w;
        w = DW'(i) ^ 16'hC3A0;
        if (i == 32'h20) w = 16'h1234;
        return w;
    endfunction

    // SPad model: read-before-write, one-cycle read latency, filler when not reading
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end else if (spad_write_en) begin
            mem[spad_w_addr] <= spad_w_data;
        end
        if (spad_read_req) spad_r_data <= mem[spad_r_addr];
        else               spad_r_data <= 16'hDEAD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int rid, input logic v, input logic [AW-1:0] a, input logic [LW-1:0] l);
        bif.req_valid[rid]          = v;
        bif.req_addr[rid*AW +: AW]  = a;
        bif.req_len[rid*LW +: LW]   = l;
    endtask

    task automatic run_burst(input vec_t v);
        int            beats;
        logic [AW-1:0] last_addr;
        beats     = int'(v.len) + 1;
        last_addr = '0;
        for (int k = 0; k <= beats + 1; k++) begin
            @(negedge clk);
            if (k == 0) set_req(v.rid, 1'b1, v.addr, v.len);
            else        set_req(v.rid, 1'b0, v.addr, v.len);
            #1;
            check("burst_ready", bif.req_ready, (k == 0) ? (32'd1 << v.rid) : 32'd0);
            if (k >= 1 && k <= beats) begin
                check("burst_rd_req", spad_read_req, 32'd1);
                check("burst_addr", spad_r_addr, AW'(v.addr + AW'(k - 1)));
                if (k == beats) last_addr = spad_r_addr;
            end else if (k == beats + 1) begin
                check("burst_rd_idle", spad_read_req, 32'd0);
            end
            if (k >= 2) begin
                check("burst_rsp_valid", bif.rsp_valid, 32'd1);
                check("burst_rsp_id", bif.rsp_id, v.rid);
                check("burst_rsp_data", bif.rsp_data, mem[AW'(v.addr + AW'(k - 2))]);
                check("burst_rsp_last", bif.rsp_last, (k == beats + 1) ? 32'd1 : 32'd0);
            end else begin
                check("burst_rsp_idle", bif.rsp_valid, 32'd0);
                check("burst_rsp_zero", bif.rsp_data, 32'd0);
            end
        end
        check("burst_last_addr", last_addr, v.exp_last);
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{rid: 0, addr: 9'h010, len: 4'd3,  exp_last: 9'h013};
        vecs[1] = '{rid: 1, addr: 9'h1FE, len: 4'd3,  exp_last: 9'h001};
        vecs[2] = '{rid: 2, addr: 9'h100, len: 4'd0,  exp_last: 9'h100};
        vecs[3] = '{rid: 3, addr: 9'h0A0, len: 4'd15, exp_last: 9'h0AF};
        vecs[4] = '{rid: 2, addr: 9'h1FF, len: 4'd1,  exp_last: 9'h000};

        bif.req_valid = '0;
        bif.req_addr  = '0;
        bif.req_len   = '0;
        wr_en   = 1'b1;
        wr_addr = 9'h033;
        wr_data = 16'h7777;
        reset   = 1'b0;

        // Reset with requests and a write pending: everything must stay quiet
        bif.req_valid = 4'b1111;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", bif.req_ready, 32'd0);
        check("rst_rd_req", spad_read_req, 32'd0);
        check("rst_r_addr", spad_r_addr, 32'd0);
        check("rst_rsp_valid", bif.rsp_valid, 32'd0);
        check("rst_rsp_id", bif.rsp_id, 32'd0);
        check("rst_rsp_last", bif.rsp_last, 32'd0);
        check("rst_rsp_data", bif.rsp_data, 32'd0);
        check("rst_wr_en", spad_write_en, 32'd0);
        bif.req_valid = '0;
        wr_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) run_burst(vecs[i]);

        // Same-cycle write/read collision on 0x020
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            set_req(0, (k == 0), 9'h020, 4'd0);
            wr_en   = (k == 1);
            wr_addr = 9'h020;
            wr_data = 16'hBEEF;
            #1;
            if (k == 1) begin
                check("coll_rd_addr", spad_r_addr, 32'h020);
                check("coll_wr_en", spad_write_en, 32'd1);
            end
            if (k == 2) begin
                check("coll_rsp_valid", bif.rsp_valid, 32'd1);
`ifdef SPAD_ARB_WR_BYPASS_EN
                check("coll_rsp_data", bif.rsp_data, 32'hBEEF);
`else
                check("coll_rsp_data", bif.rsp_data, 32'h1234);
`endif
            end
            if (k == 3) check("coll_rsp_done", bif.rsp_valid, 32'd0);
        end

        // Write port pass-through
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 9'h1F0; wr_data = 16'h5A5A;
        #1;
        check("pt_wr_en", spad_write_en, 32'd1);
        check("pt_w_addr", spad_w_addr, 32'h1F0);
        check("pt_w_data", spad_w_data, 32'h5A5A);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        check("pt_wr_off", spad_write_en, 32'd0);

        // Reset during beat 2 of a len-7 burst
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            set_req(1, (k == 0), 9'h080, 4'd7);
            if (k == 3) reset = 1'b0;
            if (k == 5) reset = 1'b1;
            #1;
            if (k == 0) check("mid_ready", bif.req_ready, 32'h2);
            if (k == 3) check("mid_beat2_id", bif.rsp_id, 32'd1);
            if (k == 4) begin
                check("mid_rst_rd_req", spad_read_req, 32'd0);
                check("mid_rst_r_addr", spad_r_addr, 32'd0);
                check("mid_rst_valid", bif.rsp_valid, 32'd0);
                check("mid_rst_data", bif.rsp_data, 32'd0);
                check("mid_rst_id", bif.rsp_id, 32'd0);
                check("mid_rst_last", bif.rsp_last, 32'd0);
            end
            if (k >= 5) begin
                check("mid_after_rd", spad_read_req, 32'd0);
                check("mid_after_valid", bif.rsp_valid, 32'd0);
            end
        end

        // Fairness: all four requesting len-0 bursts back to back
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(9'h040 + AW'(i)), 4'd0);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            bif.req_valid = (k <= 7) ? 4'b1111 : 4'b0000;
            #1;
            check("fair_ready", bif.req_ready, (k <= 7) ? (32'd1 << (k % 4)) : 32'd0);
            check("fair_rd_req", spad_read_req, (k >= 1 && k <= 8) ? 32'd1 : 32'd0);
            if (k >= 1 && k <= 8) check("fair_addr", spad_r_addr, 32'h040 + ((k - 1) % 4));
            check("fair_rsp_valid", bif.rsp_valid, (k >= 2 && k <= 9) ? 32'd1 : 32'd0);
            if (k >= 2 && k <= 9) begin
                check("fair_rsp_id", bif.rsp_id, (k - 2) % 4);
                check("fair_rsp_last", bif.rsp_last, 32'd1);
                check("fair_rsp_data", bif.rsp_data, mem[9'h040 + AW'((k - 2) % 4)]);
            end
        end

        // Withdrawn request: req 2 leaves before the pointer reaches it, req 3 wins
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            set_req(1, (k == 0), 9'h0C0, 4'd3);
            set_req(2, (k == 1), 9'h0D0, 4'd0);
            set_req(3, (k >= 1 && k <= 4), 9'h0E0, 4'd0);
            #1;
            if (k == 0)               check("wd_ready0", bif.req_ready, 32'h2);
            if (k >= 1 && k <= 3)     check("wd_ready_busy", bif.req_ready, 32'd0);
            if (k == 4)               check("wd_ready3", bif.req_ready, 32'h8);
            if (k == 5) begin
                check("wd_ready_off", bif.req_ready, 32'd0);
                check("wd_addr3", spad_r_addr, 32'h0E0);
                check("wd_prev_last", bif.rsp_last, 32'd1);
                check("wd_prev_id", bif.rsp_id, 32'd1);
            end
            if (k == 6) begin
                check("wd_rsp_id3", bif.rsp_id, 32'd3);
                check("wd_rsp_data3", bif.rsp_data, mem[9'h0E0]);
                check("wd_rd_idle", spad_read_req, 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
